// File: rtl/vip_bit_erosion_3x3.sv
// Binary 3x3 erosion of the 1-bit Sobel edge stream. The window is built from
// two line buffers, and the framing signals pass through a fixed 3-clk delay.
module vip_bit_erosion_3x3 #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
);

  logic       acc;
  logic       lb_shift;
  logic [9:0] x;
  logic [9:0] y;
  logic       synced;
  logic       vsync_prev;
  logic       href_prev;

  logic [2:0] vsync_d;
  logic [2:0] href_d;
  logic [2:0] clken_d;

  logic [IMG_HDISP-1:0] lb0;
  logic [IMG_HDISP-1:0] lb1;
  logic                 lb0_out;
  logic                 lb1_out;

  // Bit 0 of each window row is the newest column (x), bit 2 the oldest (x-2).
  logic [2:0] win_r0;
  logic [2:0] win_r1;
  logic [2:0] win_r2;

  logic valid_s1;
  logic res_s2;

  assign acc      = per_frame_clken & per_frame_href;
  assign lb_shift = acc & (x < IMG_HDISP);
  assign lb0_out  = lb0[IMG_HDISP-1];
  assign lb1_out  = lb1[IMG_HDISP-1];

  assign post_frame_vsync = vsync_d[2];
  assign post_frame_href  = href_d[2];
  assign post_frame_clken = clken_d[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= '0;
      href_d  <= '0;
      clken_d <= '0;
    end else begin
      vsync_d <= {vsync_d[1:0], per_frame_vsync};
      href_d  <= {href_d[1:0], per_frame_href};
      clken_d <= {clken_d[1:0], per_frame_clken};
    end
  end

  // vsync_prev resets high so a frame already running at reset release is
  // not mistaken for a new frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev <= 1'b1;
      href_prev  <= 1'b0;
      synced     <= 1'b0;
    end else begin
      vsync_prev <= per_frame_vsync;
      href_prev  <= per_frame_href;
      if (per_frame_vsync && !vsync_prev)
        synced <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
    end else if (!per_frame_href) begin
      x <= '0;
    end else if (acc && (x < IMG_HDISP)) begin
      x <= x + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (!per_frame_vsync) begin
      y <= '0;
    end else if (href_prev && !per_frame_href && (y < IMG_VDISP)) begin
      y <= y + 10'd1;
    end
  end

  // Line buffer contents are masked by y < 2 after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (lb_shift) begin
      lb0 <= {lb0[IMG_HDISP-2:0], per_img_Bit};
      lb1 <= {lb1[IMG_HDISP-2:0], lb0_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_r0   <= '0;
      win_r1   <= '0;
      win_r2   <= '0;
      valid_s1 <= 1'b0;
    end else begin
      if (acc) begin
        win_r0 <= {win_r0[1:0], lb1_out};
        win_r1 <= {win_r1[1:0], lb0_out};
        win_r2 <= {win_r2[1:0], per_img_Bit};
      end
      valid_s1 <= acc & synced & (x >= 10'd2) & (y >= 10'd2) &
                  (x < IMG_HDISP) & (y < IMG_VDISP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_s2       <= 1'b0;
      post_img_Bit <= 1'b0;
    end else begin
      res_s2       <= valid_s1 & (&{win_r0, win_r1, win_r2});
      post_img_Bit <= res_s2 & clken_d[1];
    end
  end

endmodule

// File: tb/tb_vip_bit_erosion_3x3.sv
// Randomized bench for vip_bit_erosion_3x3 at 8x6, checked against an
// image-array reference model with a 3-clk expected-output delay line.
module tb_vip_bit_erosion_3x3;

  localparam int H = 8;
  localparam int V = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs, hr, ck, b;
  logic post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;

  always #5 clk = ~clk;

  vip_bit_erosion_3x3 #(
    .IMG_HDISP(10'd8),
    .IMG_VDISP(10'd6)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ck),
    .per_img_Bit      (b),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Bit     (post_img_Bit)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ones   = 0;
  int cyc    = 0;
  int n;

  // Reference model state: frame image, counters and expected output delay line.
  bit         img [0:V-1][0:H-1];
  int         m_row, m_col;
  bit         m_sync, m_vprev, m_hprev;
  logic [3:0] pipe [3];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    bit a, e;
    if (rst) begin
      pipe    = '{default: '0};
      m_sync  = 0;
      m_vprev = 1;
      m_hprev = 0;
      m_row   = 0;
      m_col   = 0;
    end else begin
      a = ck & hr;
      e = 0;
      if (a && m_col < H && m_row < V) img[m_row][m_col] = b;
      if (a && m_sync && m_col >= 2 && m_row >= 2 && m_col < H && m_row < V) begin
        e = 1;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            if (!img[m_row-dy][m_col-dx]) e = 0;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {vs, hr, ck, e};
      if (vs && !m_vprev) m_sync = 1;
      if (!hr) m_col = 0;
      else if (a && m_col < H) m_col++;
      if (!vs) m_row = 0;
      else if (m_hprev && !hr && m_row < V) m_row++;
      m_hprev = hr;
      m_vprev = vs;
    end
  endtask

  task automatic step(input logic v, input logic h, input logic c, input logic bi);
    vs = v; hr = h; ck = c; b = bi;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("post_vsync", post_frame_vsync, pipe[2][3]);
    check("post_href",  post_frame_href,  pipe[2][2]);
    check("post_clken", post_frame_clken, pipe[2][1]);
    check("post_bit",   post_img_Bit,     pipe[2][0]);
    if (post_img_Bit) ones++;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_vsync", post_frame_vsync, 0);
    check("rst_async_href",  post_frame_href,  0);
    check("rst_async_clken", post_frame_clken, 0);
    check("rst_async_bit",   post_img_Bit,     0);
    step(vs, hr, ck, b);
    rst = 1'b0;
  endtask

  function automatic logic pat(input int kind, input int x, input int y);
    case (kind)
      0:       return 1'b1;
      1:       return !(x == 4 && y == 3);
      2:       return ((x + y) % 2) == 1;
      default: return $urandom_range(0, 99) < 88;
    endcase
  endfunction

  // gap: 0 contiguous clken, 1 every 3rd cycle, 2 random gaps
  task automatic frame(input int kind, input int len, input int gap,
                       input int rst_row, output int n1);
    int  x;
    bit  done;
    logic c;
    done = 0;
    ones = 0;
    repeat (3) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < V; y++) begin
      x = 0;
      while (x < len) begin
        if (y == rst_row && x == 4 && !done) begin
          pulse_reset();
          done = 1;
        end
        case (gap)
          0:       c = 1'b1;
          1:       c = (cyc % 3) == 0;
          default: c = $urandom_range(0, 2) != 0;
        endcase
        step(1'b1, 1'b1, c, c ? pat(kind, x, y) : 1'($urandom_range(0, 1)));
        if (c) x++;
      end
      repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    n1 = ones;
  endtask

  initial begin
    vs = 0; hr = 0; ck = 0; b = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    frame(0, H,  0, -1, n); check("ones_full",       n, 24);
    frame(1, H,  0, -1, n); check("ones_hole",       n, 15);
    frame(0, H,  1, -1, n); check("ones_every3rd",   n, 24);
    frame(0, H,  0,  3, n);
    frame(0, H,  0, -1, n); check("ones_after_rst",  n, 24);
    frame(2, H,  2, -1, n); check("ones_checker",    n, 0);
    frame(0, 10, 0, -1, n); check("ones_long_line",  n, 24);
    frame(0, 10, 2, -1, n); check("ones_long_gaps",  n, 24);
    repeat (6) frame(3, H, 2, -1, n);
    frame(3, 10, 0, -1, n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
